veririsc_controller: RTL

Instruction sequencer for the VeriRISC CPU. It steps through a fixed 8-phase instruction cycle and decodes the current opcode and accumulator-zero flag into the datapath strobes. These strobes include `ld_pc`/`inc_pc`, the load and enable inputs of the program counter, and the register, memory and ALU controls. It sits between the instruction register and every loadable/enabled register in the CPU.

---
 rtl/veririsc_pkg.sv | 57 +++++
 rtl/ctrl_phase_cnt.sv | 45 ++++
 rtl/veririsc_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/veririsc_pkg.sv
// -----------------------------------------------------------------------------
// veririsc_pkg
// Shared definitions for the VeriRISC controller slice.
//   - OP_W / PHASE_W : opcode and phase-counter widths
//   - opcode_e       : instruction opcodes HLT..JMP
//   - phase_e        : the eight instruction-cycle phases INST_ADDR..STORE
//   - strobes_t      : bundle of all datapath control strobes
//   - is_aluop()     : true for opcodes whose operand is read from memory
//                      and routed through the ALU into the accumulator
// -----------------------------------------------------------------------------
package veririsc_pkg;

   localparam int OP_W    = 3;
   localparam int PHASE_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_e;

   typedef enum logic [PHASE_W-1:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic halt;
      logic data_e;
      logic ld_ac;
      logic wr;
   } strobes_t;

   localparam strobes_t STROBES_IDLE = '0;

   // Opcodes that fetch an operand from memory and load the accumulator.
   function automatic logic is_aluop(input opcode_e op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage : veririsc_pkg

// File: rtl/ctrl_phase_cnt.sv
// -----------------------------------------------------------------------------
// ctrl_phase_cnt
// Wrapping phase counter for the VeriRISC instruction cycle. Counts
// 0..2**PHASE_W-1 and wraps to 0, advancing one step per clock while enab is
// high. The parent gates enab with its halted flag.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset, forces phase to 0
//   enab   in   advance enable
//   phase  out  current phase (PHASE_W bits)
// -----------------------------------------------------------------------------
module ctrl_phase_cnt #(
   parameter int PHASE_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enab,
   output logic [PHASE_W-1:0] phase
);

   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] phase_d;

   // Natural binary overflow provides the STORE -> INST_ADDR wrap.
   always_comb begin
      phase_d = phase_q;
      if (enab) begin
         phase_d = phase_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule : ctrl_phase_cnt

// File: rtl/veririsc_controller.sv
// -----------------------------------------------------------------------------
// veririsc_controller
// Instruction sequencer for the VeriRISC CPU. Steps through the fixed
// 8-phase instruction cycle and decodes the current phase, opcode and
// accumulator-zero flag into the datapath strobes. Strobes are purely
// combinational from the phase register; there is no output register stage.
//
// Build option:
//   VERIRISC_CTRL_HALT_LATCH_EN
//     defined   : HLT in an enabled OP_ADDR cycle sets a sticky halted flag;
//                 the phase then freezes at OP_FETCH with only halt asserted
//                 until rst.
//     undefined : halt is a single-phase pulse in OP_ADDR and the phase keeps
//                 cycling; stopping the clock is left to the CPU top.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset (priority over enab and halt)
//   enab    in   phase advance enable
//   opcode  in   instruction register opcode field (OP_W bits)
//   zero    in   accumulator-is-zero flag
//   phase   out  current phase (debug)
//   sel     out  address mux select, 1 = PC, 0 = IR operand
//   rd      out  memory read
//   ld_ir   out  instruction register load
//   inc_pc  out  program counter increment
//   ld_pc   out  program counter load (PC gives load priority over inc)
//   halt    out  halt indication
//   data_e  out  accumulator-to-bus driver enable
//   ld_ac   out  accumulator load
//   wr      out  memory write
// -----------------------------------------------------------------------------
module veririsc_controller #(
   parameter int PHASE_W = 3,
   parameter int OP_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enab,
   input  logic [OP_W-1:0]    opcode,
   input  logic               zero,
   output logic [PHASE_W-1:0] phase,
   output logic               sel,
   output logic               rd,
   output logic               ld_ir,
   output logic               inc_pc,
   output logic               ld_pc,
   output logic               halt,
   output logic               data_e,
   output logic               ld_ac,
   output logic               wr
);

   import veririsc_pkg::*;

   logic [PHASE_W-1:0] phase_cnt;
   logic               cnt_enab;
   logic               halted;
   phase_e             ph;
   opcode_e            op;
   strobes_t           strb;

   assign ph = phase_e'(phase_cnt);
   assign op = opcode_e'(opcode);

   // --------------------------------------------------------------------------
   // Halt handling
   // --------------------------------------------------------------------------
`ifdef VERIRISC_CTRL_HALT_LATCH_EN
   // Sets on the edge that leaves an enabled OP_ADDR with HLT; the counter
   // takes that same edge to OP_FETCH and then stays there.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted <= 1'b0;
      end else if (enab && (ph == PH_OP_ADDR) && (op == OP_HLT)) begin
         halted <= 1'b1;
      end
   end
`else
   assign halted = 1'b0;
`endif

   assign cnt_enab = enab & ~halted;

   // --------------------------------------------------------------------------
   // Phase register
   // --------------------------------------------------------------------------
   ctrl_phase_cnt #(
      .PHASE_W (PHASE_W)
   ) u_phase_cnt (
      .clk   (clk),
      .rst   (rst),
      .enab  (cnt_enab),
      .phase (phase_cnt)
   );

   // --------------------------------------------------------------------------
   // Strobe decode
   // --------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no
   // path through the block leaves a signal unassigned (which would infer a
   // latch).
   always_comb begin
      strb = STROBES_IDLE;
      if (halted) begin
         strb.halt = 1'b1;
      end else begin
         unique case (ph)
            PH_INST_ADDR: begin
               strb.sel = 1'b1;
            end
            PH_INST_FETCH: begin
               strb.sel = 1'b1;
               strb.rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               strb.sel   = 1'b1;
               strb.rd    = 1'b1;
               strb.ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               strb.inc_pc = 1'b1;
               strb.halt   = (op == OP_HLT);
            end
            PH_OP_FETCH: begin
               strb.rd = is_aluop(op);
            end
            PH_ALU_OP: begin
               strb.rd     = is_aluop(op);
               strb.inc_pc = (op == OP_SKZ) && zero;
               strb.ld_pc  = (op == OP_JMP);
               strb.data_e = (op == OP_STO);
            end
            PH_STORE: begin
               // JMP raises inc_pc and ld_pc together; the PC resolves to load.
               strb.rd     = is_aluop(op);
               strb.inc_pc = (op == OP_JMP);
               strb.ld_pc  = (op == OP_JMP);
               strb.ld_ac  = is_aluop(op);
               strb.wr     = (op == OP_STO);
               strb.data_e = (op == OP_STO);
            end
         endcase
      end
   end

   assign phase  = phase_cnt;
   assign sel    = strb.sel;
   assign rd     = strb.rd;
   assign ld_ir  = strb.ld_ir;
   assign inc_pc = strb.inc_pc;
   assign ld_pc  = strb.ld_pc;
   assign halt   = strb.halt;
   assign data_e = strb.data_e;
   assign ld_ac  = strb.ld_ac;
   assign wr     = strb.wr;

endmodule : veririsc_controller
